// File: rtl/shift_rotate_sequencer_if.sv
// Request/response bundle for the shift/rotate stage.
// The DUT uses the slave modport. The producer/consumer side uses master.
interface shift_rotate_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_err;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, in_op, in_a, in_amt, out_ready,
        input  in_ready, out_valid, out_result, out_err, op_count
    );

    modport slave (
        input  in_valid, in_op, in_a, in_amt, out_ready,
        output in_ready, out_valid, out_result, out_err, op_count
    );
endinterface

// File: rtl/shift_rotate_sequencer.sv
// Two-stage shift/rotate stage with valid/ready flow control on both sides.
// Stage 1 captures the request. Stage 2 holds the result until it is taken.
module shift_rotate_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     clr,
    shift_rotate_sequencer_if.slave  bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ROR  = 3'd0;
    localparam logic [2:0] OP_ROL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_SHRA = 3'd4;

    logic               r_s1_v;
    logic [2:0]         r_s1_op;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_amt;

    logic               r_s2_v;
    logic               r_s2_err;
    logic [WIDTH-1:0]   r_s2_res;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_s2_acc;
    logic               w_in_ready;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_adv;

    logic [SH_W-1:0]    w_sh;
    logic               w_big;
    logic [2*WIDTH-1:0] w_dbl;
    logic [2*WIDTH-1:0] w_ror_full;
    logic [2*WIDTH-1:0] w_rol_full;
    logic [WIDTH-1:0]   w_res;
    logic               w_err;

    assign w_s2_acc   = !r_s2_v || bus.out_ready;
    assign w_in_ready = !r_s1_v || w_s2_acc;
    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = r_s2_v && bus.out_ready;
    assign w_adv      = r_s1_v && w_s2_acc;

    assign w_sh  = r_s1_amt[SH_W-1:0];
    assign w_big = |r_s1_amt[WIDTH-1:SH_W];

    // Rotates use a doubled operand so a single shift covers every amount, including zero.
    always_comb begin
        w_res      = r_s1_a;
        w_err      = 1'b0;
        w_dbl      = {r_s1_a, r_s1_a};
        w_ror_full = w_dbl >> w_sh;
        w_rol_full = w_dbl << w_sh;
        case (r_s1_op)
            OP_ROR:  w_res = w_ror_full[WIDTH-1:0];
            OP_ROL:  w_res = w_rol_full[2*WIDTH-1:WIDTH];
            OP_SHR:  w_res = w_big ? '0 : (r_s1_a >> w_sh);
            OP_SHL:  w_res = w_big ? '0 : (r_s1_a << w_sh);
            OP_SHRA: w_res = w_big ? {WIDTH{r_s1_a[WIDTH-1]}}
                                   : WIDTH'($signed(r_s1_a) >>> w_sh);
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_s1_v   <= 1'b0;
            r_s1_op  <= '0;
            r_s1_a   <= '0;
            r_s1_amt <= '0;
            r_s2_v   <= 1'b0;
            r_s2_err <= 1'b0;
            r_s2_res <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_in_xfer) begin
                r_s1_v   <= 1'b1;
                r_s1_op  <= bus.in_op;
                r_s1_a   <= bus.in_a;
                r_s1_amt <= bus.in_amt;
            end else if (w_adv) begin
                r_s1_v <= 1'b0;
            end

            if (w_s2_acc) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_res <= w_res;
                    r_s2_err <= w_err;
                end
            end

            if (w_out_xfer && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_s2_v;
    assign bus.out_result = r_s2_res;
    assign bus.out_err    = r_s2_err;
    assign bus.op_count   = r_cnt;
endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Bench for shift_rotate_sequencer: expected responses are queued at issue and checked by a monitor.
// A second instance with a 4-bit counter covers saturation.
module tb_shift_rotate_sequencer;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    shift_rotate_sequencer_if #(.WIDTH(32), .CNT_W(16)) bus  ();
    shift_rotate_sequencer_if #(.WIDTH(32), .CNT_W(4))  bus2 ();

    shift_rotate_sequencer #(.WIDTH(32), .CNT_W(16)) dut  (.clk(clk), .clr(clr), .bus(bus.slave));
    shift_rotate_sequencer #(.WIDTH(32), .CNT_W(4))  dut2 (.clk(clk), .clr(clr), .bus(bus2.slave));

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          stamp;
        bit          strict;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_sent = 0;
    int   n_pop  = 0;
    int   mode   = 1;     // 0: out_ready low, 1: high, 2: random
    bit   mon_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: rotations one bit at a time, shifts as multiply/divide by powers of two.
    function automatic logic [32:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] amt);
        logic [31:0] r;
        int          n;
        r = a;
        case (op)
            0: begin
                n = int'(amt % 32);
                for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
            end
            1: begin
                n = int'(amt % 32);
                for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
            end
            2: r = (amt >= 32) ? 32'd0 : a / (32'd1 << amt);
            3: r = (amt >= 32) ? 32'd0 : a * (32'd1 << amt);
            4: begin
                if (amt >= 32) r = a[31] ? 32'hFFFF_FFFF : 32'd0;
                else if (a[31]) r = ~((~a) / (32'd1 << amt));
                else r = a / (32'd1 << amt);
            end
            default: return {1'b1, a};
        endcase
        return {1'b0, r};
    endfunction

    always @(negedge clk) begin
        if (mode == 0)      bus.out_ready = 1'b0;
        else if (mode == 1) bus.out_ready = 1'b1;
        else                bus.out_ready = ($urandom_range(0, 9) < 6);
    end

    // Present one request and push its expected response once the handshake is seen.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] amt,
                        input logic [31:0] eres, input logic eerr);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_amt   = amt;
        forever begin
            #4;
            if (bus.in_ready) break;
            guard++;
            if (guard > 300) begin
                chk("send_timeout", 64'd0, 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        e.res    = eres;
        e.err    = eerr;
        e.stamp  = cyc;
        e.strict = (mode == 1);
        q.push_back(e);
        n_sent++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] amt);
        logic [32:0] r;
        r = ref_op(int'(op), a, amt);
        send(op, a, amt, r[31:0], r[32]);
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while ((q.size() != 0 || bus.out_valid) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_drained"}, 64'(q.size()), 64'd0);
        chk({name, "_count"}, 64'(bus.op_count), 64'(n_sent));
    endtask

    // Monitor: every output transfer pops one expectation; a stalled output must match the head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en && bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 64'd1, 64'd0);
                end else if (bus.out_ready) begin
                    e = q.pop_front();
                    chk("result", 64'(bus.out_result), 64'(e.res));
                    chk("err", 64'(bus.out_err), 64'(e.err));
                    if (e.strict) chk("latency", 64'(cyc - e.stamp), 64'd2);
                    chk("op_count_running", 64'(bus.op_count), 64'(n_pop));
                    n_pop++;
                end else begin
                    chk("stall_hold", 64'({bus.out_err, bus.out_result}), 64'({q[0].err, q[0].res}));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          x2;
        bus.in_valid = 1'b0;
        bus.in_op = '0; bus.in_a = '0; bus.in_amt = '0;
        bus2.in_valid = 1'b0;
        bus2.in_op = '0; bus2.in_a = '0; bus2.in_amt = '0;
        bus2.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        clr = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_op_count", 64'(bus.op_count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        mode = 1;
        send(3'd0, 32'h8000_0001, 32'd1,  32'hC000_0000, 1'b0);
        send(3'd0, 32'h8000_0001, 32'd33, 32'hC000_0000, 1'b0);
        send(3'd1, 32'h8000_0001, 32'd4,  32'h0000_0018, 1'b0);
        send(3'd2, 32'hF000_0000, 32'd4,  32'h0F00_0000, 1'b0);
        send(3'd4, 32'hF000_0000, 32'd4,  32'hFF00_0000, 1'b0);
        send(3'd4, 32'hF000_0000, 32'd40, 32'hFFFF_FFFF, 1'b0);
        send(3'd3, 32'hF000_0001, 32'd32, 32'h0000_0000, 1'b0);
        wait_drain("directed");

        a = $urandom();
        send(3'd0, a, 32'd0, a, 1'b0);
        for (int k = 1; k < 8; k++) send_ref(3'd0, a, 32'(k));
        wait_drain("stream8");
        chk("stream8_total", 64'(bus.op_count), 64'd15);

        send(3'd6, 32'h1234_5678, 32'd5, 32'h1234_5678, 1'b1);
        send(3'd2, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0);
        send(3'd7, 32'hDEAD_BEEF, 32'd9, 32'hDEAD_BEEF, 1'b1);
        send(3'd1, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b0);
        wait_drain("illegal");

        // Backpressure: three requests against a stalled consumer, then release.
        mode = 0;
        fork
            begin
                send_ref(3'd1, 32'hA5A5_0001, 32'd3);
                send_ref(3'd4, 32'h8765_4321, 32'd7);
                send_ref(3'd3, 32'h0000_FFFF, 32'd12);
            end
            begin
                repeat (6) @(negedge clk);
                #4;
                chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
                chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
                mode = 1;
            end
        join
        wait_drain("backpressure");

        // Asynchronous clear with both stages occupied.
        mode = 0;
        send_ref(3'd0, 32'h1357_9BDF, 32'd8);
        send_ref(3'd2, 32'h2468_ACE0, 32'd1);
        repeat (2) @(negedge clk);
        #2;
        chk("pre_clr_valid", 64'(bus.out_valid), 64'd1);
        chk("pre_clr_in_ready", 64'(bus.in_ready), 64'd0);
        mon_en = 1'b0;
        clr = 1'b1;
        #1;
        chk("async_clr_valid", 64'(bus.out_valid), 64'd0);
        chk("async_clr_result", 64'(bus.out_result), 64'd0);
        chk("async_clr_count", 64'(bus.op_count), 64'd0);
        q.delete();
        n_sent = 0;
        n_pop  = 0;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("post_clr_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_clr_valid", 64'(bus.out_valid), 64'd0);
        mon_en = 1'b1;

        // Random traffic with random consumer backpressure.
        mode = 2;
        for (int k = 0; k < 150; k++) begin
            logic [31:0] amt;
            amt = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom();
            send_ref(3'($urandom_range(0, 7)), $urandom(), amt);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        mode = 1;
        wait_drain("random");

        // Counter saturation on the 4-bit instance.
        x2 = 0;
        @(negedge clk);
        bus2.in_op    = 3'd1;
        bus2.in_a     = $urandom();
        bus2.in_amt   = 32'd3;
        bus2.in_valid = 1'b1;
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            if (k == 22) bus2.in_valid = 1'b0;
            #4;
            if (bus2.out_valid && bus2.out_ready) x2++;
        end
        chk("sat_reached", 64'(x2 >= 16), 64'd1);
        chk("sat_count", 64'(bus2.op_count), 64'((x2 > 15) ? 15 : x2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_rotate_sequencer.md
Name: shift_rotate_sequencer

Overview:
- Two-stage pipelined shift/rotate execution stage for the 32-bit datapath. It sits directly upstream of the ALU result (Z) capture.
- Accepts operand, amount and opcode over a valid/ready handshake, registers them, and computes ROR/ROL/SHR/SHL/SHRA.
- Holds each result in an output register until the downstream consumer takes it.
- Provides full throughput with backpressure and a completed-operation counter for debug.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  stage can accept a request this cycle.
- in_op  input  3  opcode: 0 ROR, 1 ROL, 2 SHR, 3 SHL, 4 SHRA, 5-7 illegal.
- in_a  input  WIDTH  operand.
- in_amt  input  WIDTH  shift/rotate amount (full 32-bit register value).
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result this cycle.
- out_result  output  WIDTH  result.
- out_err  output  1  result came from an illegal opcode.
- op_count  output  CNT_W  saturating count of completed output transfers.

Behaviour:
- **Reset:** clr asserts asynchronously, independent of clk, and clears both stages. out_valid=0, out_result=0, out_err=0, op_count=0. in_ready is 1 immediately after reset releases. A transaction in flight when clr asserts is discarded, with no partial output.
- **Transfers:** input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- **Stage 1 (S1):** registers op, a and amt, plus valid bit s1_v.
- **Stage 2 (S2):** registers result, err and valid bit; drives out_*.
- **Advance rules:**
  - S2 accepts when !out_valid || out_ready.
  - S1 advances into S2 when s1_v && (S2 accepts).
  - in_ready = !s1_v || (S2 accepts). This is combinational from out_ready; there is no combinational path from in_valid.
- **Latency and throughput:** latency is 2 cycles from accepted input to out_valid, with no stall. Throughput is 1 op/cycle while out_ready is held high.
- **Stall:** while out_valid && !out_ready, the registered outputs hold stable. S1 holds its contents, and in_ready=0 if S1 is full.
- **Bubbles:** allowed anywhere; s1_v clears when S1 advances without a new input transfer.
- **Simultaneous events:** input transfer, S1→S2 advance and output transfer in the same cycle all take effect together with no loss or duplication.
- **Arithmetic (computed from S1 contents, registered into S2):**
  - ROR: rotate right by amt[4:0]; upper amount bits are ignored.
  - ROL: rotate left by amt[4:0]; upper amount bits are ignored.
  - SHR: logical right shift, zero fill. Result is 0 if amt ≥ 32 (any bit of amt[31:5] set).
  - SHL: logical left shift, zero fill. Result is 0 if amt ≥ 32.
  - SHRA: arithmetic right shift, sign fill. Result is all copies of a[31] if amt ≥ 32.
  - Amount 0 returns a unchanged for every legal op.
  - Illegal op (5-7): result = a, err=1. Otherwise err=0.
- **op_count:** increments by 1 on each output transfer and saturates at all-ones, with no wrap.

Test Plan:
1. Reset: hold clr high, then release → out_valid=0, out_result=0, op_count=0, in_ready=1. Assert clr with both stages full → out_valid drops without waiting for a clk edge.
2. ROR, a=0x80000001, amt=1, out_ready=1 → out_result=0xC0000000 two cycles after acceptance. Repeat with amt=33 → 0xC0000000 (mod 32).
3. ROL, a=0x80000001, amt=4 → 0x00000018. SHR, a=0xF0000000, amt=4 → 0x0F000000. SHRA, same a and amt → 0xFF000000. SHRA with amt=40 → 0xFFFFFFFF. SHL with amt=32 → 0x00000000.
4. Back-to-back stream of 8 ROR ops with amt=0..7 and out_ready=1 → one result per cycle in order. op_count=8. Each amt=0 result equals a.
5. Backpressure:
   - Send 3 ops with out_ready=0 → first result appears and holds stable; in_ready goes 0 once S1 is full.
   - Raise out_ready → all 3 results delivered in order with none lost.
6. Illegal op=6, a=0x12345678 → out_result=0x12345678, out_err=1. The following legal op returns out_err=0. Force op_count to near-max through 2^CNT_W transfers (or CNT_W=4 build) → count saturates at 0xF.
